// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the CPU front end.
// Holds the instruction/PC widths, the 5-bit opcode map, the fetch FSM
// state encoding and the next-PC select encoding used by fetch_pc_reg.
package cpu_isa_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 9;
    localparam int OPC_W   = 5;

    // Opcode map (instr[8:4]); operand lives in instr[3:0].
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00011;
    localparam logic [OPC_W-1:0] OP_XOR  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00111;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_BNE  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;
    localparam logic [OPC_W-1:0] OP_TBD  = 5'b11111;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_DRAIN  = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (PC -> RESET_PC)
//   i_sel         next-PC select: hold, increment (mod 2^PC_W) or load
//   i_load_pc     target PC used when i_sel == PC_LOAD
//   o_pc          current PC
module fetch_pc_reg
    import cpu_isa_pkg::*;
#(
    parameter int              PC_W_P   = PC_W,
    parameter logic [PC_W_P-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_t           i_sel,
    input  logic [PC_W_P-1:0] i_load_pc,
    output logic [PC_W_P-1:0] o_pc
);

    logic [PC_W_P-1:0] r_pc;
    logic [PC_W_P-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_INC:  w_pc_next = r_pc + 1'b1;   // wraps naturally at 2^PC_W
            PC_LOAD: w_pc_next = i_load_pc;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC (via fetch_pc_reg), addresses the combinational
// instruction ROM and registers the result into the IF/ID slot.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rom_pc / rom_instr   ROM address (current PC) and same-cycle ROM data
//   stall                hold PC and IF/ID contents
//   redirect/redirect_pc taken branch/jump target; squashes the IF/ID slot
//   halt_commit          halt retired in writeback; completes halt draining
//   if_valid/if_instr/if_pc  IF/ID pipeline register
//   halted               core halted, no further fetch until reset
module instruction_fetch_unit
    import cpu_isa_pkg::*;
#(
    parameter int                  PC_W_P    = PC_W,
    parameter int                  INSTR_W_P = INSTR_W,
    parameter logic [PC_W_P-1:0]   RESET_PC  = '0,
    parameter logic [OPC_W-1:0]    HALT_OPC  = OP_HALT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PC_W_P-1:0]    rom_pc,
    input  logic [INSTR_W_P-1:0] rom_instr,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [PC_W_P-1:0]    redirect_pc,
    input  logic                 halt_commit,
    output logic                 if_valid,
    output logic [INSTR_W_P-1:0] if_instr,
    output logic [PC_W_P-1:0]    if_pc,
    output logic                 halted
);

    fetch_state_t          r_state;
    logic                  r_if_valid;
    logic [INSTR_W_P-1:0]  r_if_instr;
    logic [PC_W_P-1:0]     r_if_pc;
    logic                  r_halted;

    pc_sel_t               w_pc_sel;
    logic [PC_W_P-1:0]     w_pc;
    logic                  w_is_halt;

    assign w_is_halt = (rom_instr[INSTR_W_P-1 -: OPC_W] == HALT_OPC);

    // Next-PC select follows the same priority as the FSM below:
    // redirect > stall > fetch; a fetched halt freezes the PC on itself.
    always_comb begin
        w_pc_sel = PC_HOLD;
        case (r_state)
            FS_RUN: begin
                if (redirect)       w_pc_sel = PC_LOAD;
                else if (stall)     w_pc_sel = PC_HOLD;
                else if (w_is_halt) w_pc_sel = PC_HOLD;
                else                w_pc_sel = PC_INC;
            end
            FS_DRAIN: begin
                if (redirect)       w_pc_sel = PC_LOAD;
            end
            default: w_pc_sel = PC_HOLD;
        endcase
    end

    fetch_pc_reg #(
        .PC_W_P   (PC_W_P),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_sel     (w_pc_sel),
        .i_load_pc (redirect_pc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FS_RUN;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                FS_RUN: begin
                    if (redirect) begin
                        // Squash the wrong-path instruction in IF/ID.
                        r_if_valid <= 1'b0;
                        r_if_instr <= '0;
                        r_if_pc    <= '0;
                    end else if (!stall) begin
                        r_if_valid <= 1'b1;
                        r_if_instr <= rom_instr;
                        r_if_pc    <= w_pc;
                        if (w_is_halt) r_state <= FS_DRAIN;
                    end
                end
                FS_DRAIN: begin
                    if (redirect) begin
                        // Halt was on a wrong path: resume at the target.
                        r_if_valid <= 1'b0;
                        r_if_instr <= '0;
                        r_if_pc    <= '0;
                        r_state    <= FS_RUN;
                    end else if (halt_commit) begin
                        r_if_valid <= 1'b0;
                        r_halted   <= 1'b1;
                        r_state    <= FS_HALTED;
                    end else if (!stall) begin
                        // Halt has moved on to ID; leave a bubble behind it.
                        r_if_valid <= 1'b0;
                    end
                end
                default: begin
                    r_if_valid <= 1'b0;
                    r_halted   <= 1'b1;
                end
            endcase
        end
    end

    assign rom_pc   = w_pc;
    assign if_valid = r_if_valid;
    assign if_instr = r_if_instr;
    assign if_pc    = r_if_pc;
    assign halted   = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rom_pc;
    logic [8:0]  rom_instr;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_commit;
    logic        if_valid;
    logic [8:0]  if_instr;
    logic [15:0] if_pc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [8:0] mem [0:127];

    typedef struct {
        logic        v;
        logic [15:0] pc;
        logic [8:0]  instr;
        logic        hlt;
        bit          pay;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // ROM model: unmapped addresses return halt; 0xFFFF holds a non-halt.
    assign rom_instr = (rom_pc < 16'd128) ? mem[rom_pc[6:0]] :
                       (rom_pc == 16'hFFFF) ? 9'h0F5 : 9'h1A0;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_pc      (rom_pc),
        .rom_instr   (rom_instr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_commit (halt_commit),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".rom_pc"},   32'(rom_pc),   32'h0);
        chk({tag, ".if_valid"}, 32'(if_valid), 32'h0);
        chk({tag, ".if_instr"}, 32'(if_instr), 32'h0);
        chk({tag, ".if_pc"},    32'(if_pc),    32'h0);
        chk({tag, ".halted"},   32'(halted),   32'h0);
    endtask

    // One clock: check the current ROM address, push the expected IF/ID
    // result, drive inputs, clock, then pop and compare.
    task automatic step(input string tag, input logic st, input logic rd,
                        input logic [15:0] rpc, input logic hc,
                        input logic [15:0] e_rom, input logic ev,
                        input logic [15:0] epc, input logic [8:0] ein,
                        input logic eh, input bit pay);
        exp_t e;
        chk({tag, ".rom_pc"}, 32'(rom_pc), 32'(e_rom));
        exp_q.push_back('{v: ev, pc: epc, instr: ein, hlt: eh, pay: pay});
        stall = st; redirect = rd; redirect_pc = rpc; halt_commit = hc;
        @(posedge clk);
        #1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_commit = 1'b0;
        e = exp_q.pop_front();
        chk({tag, ".if_valid"}, 32'(if_valid), 32'(e.v));
        chk({tag, ".halted"},   32'(halted),   32'(e.hlt));
        if (e.pay) begin
            chk({tag, ".if_pc"},    32'(if_pc),    32'(e.pc));
            chk({tag, ".if_instr"}, 32'(if_instr), 32'(e.instr));
        end
        $display("step %-10s rom_pc=%h v=%b if_pc=%h if_instr=%h halted=%b",
                 tag, rom_pc, if_valid, if_pc, if_instr, halted);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; halt_commit = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 9'h1A0;
        mem[0] = 9'h0A0; mem[1] = 9'h061; mem[2] = 9'h1A0;

        // ---- Phase A: free run into halt ----
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rstA");
        rst_n = 1'b1;
        step("A.f0",   0, 0, 16'h0, 0, 16'h0, 1, 16'h0, 9'h0A0, 0, 1);
        step("A.f1",   0, 0, 16'h0, 0, 16'h1, 1, 16'h1, 9'h061, 0, 1);
        step("A.halt", 0, 0, 16'h0, 0, 16'h2, 1, 16'h2, 9'h1A0, 0, 1);
        step("A.drn1", 0, 0, 16'h0, 0, 16'h2, 0, 16'h0, 9'h0,   0, 0);
        step("A.drn2", 0, 0, 16'h0, 0, 16'h2, 0, 16'h0, 9'h0,   0, 0);
        step("A.hcom", 0, 0, 16'h0, 1, 16'h2, 0, 16'h0, 9'h0,   1, 0);
        step("A.hold", 1, 1, 16'h30, 1, 16'h2, 0, 16'h0, 9'h0,  1, 0);
        chk("A.rom_pc_frozen", 32'(rom_pc), 32'h2);

        // ---- Phase B: stall, redirect, halt squash, wrap ----
        #2 rst_n = 1'b0;
        #1 chk_reset_state("rstB");
        for (int i = 0; i < 128; i++) mem[i] = 9'h020 + 9'(i);
        mem[9] = 9'h1A9;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            step("B.run", 0, 0, 16'h0, 0, 16'(i), 1, 16'(i), 9'h020 + 9'(i), 0, 1);
        for (int i = 0; i < 3; i++)
            step("B.stall", 1, 0, 16'h0, 0, 16'h5, 1, 16'h4, 9'h024, 0, 1);
        step("B.res5",  0, 0, 16'h0,  0, 16'h5,  1, 16'h5,  9'h025, 0, 1);
        step("B.res6",  0, 0, 16'h0,  0, 16'h6,  1, 16'h6,  9'h026, 0, 1);
        step("B.rdst",  1, 1, 16'h40, 0, 16'h7,  0, 16'h0,  9'h0,   0, 1);
        step("B.f40",   0, 0, 16'h0,  0, 16'h40, 1, 16'h40, 9'h060, 0, 1);
        step("B.rd9",   0, 1, 16'h9,  0, 16'h41, 0, 16'h0,  9'h0,   0, 1);
        step("B.halt9", 0, 0, 16'h0,  0, 16'h9,  1, 16'h9,  9'h1A9, 0, 1);
        step("B.rd_hc", 0, 1, 16'h12, 1, 16'h9,  0, 16'h0,  9'h0,   0, 1);
        step("B.f12",   0, 0, 16'h0,  0, 16'h12, 1, 16'h12, 9'h032, 0, 1);
        step("B.rdFF",  0, 1, 16'hFFFF, 0, 16'h13, 0, 16'h0, 9'h0,  0, 1);
        step("B.fFFFF", 0, 0, 16'h0,  0, 16'hFFFF, 1, 16'hFFFF, 9'h0F5, 0, 1);
        step("B.wrap",  0, 0, 16'h0,  0, 16'h0,  1, 16'h0,  9'h020, 0, 1);

        // ---- Phase C: asynchronous reset mid-stall ----
        step("C.stall", 1, 0, 16'h0, 0, 16'h1, 1, 16'h0, 9'h020, 0, 1);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_state("rst_stall");
        stall = 1'b0;
        rst_n = 1'b1;
        step("C.f0",    0, 0, 16'h0, 0, 16'h0, 1, 16'h0, 9'h020, 0, 1);

        // ---- Phase D: asynchronous reset mid-DRAIN ----
        step("D.rd9",   0, 1, 16'h9, 0, 16'h1, 0, 16'h0, 9'h0,   0, 1);
        step("D.halt",  0, 0, 16'h0, 0, 16'h9, 1, 16'h9, 9'h1A9, 0, 1);
        step("D.drain", 0, 0, 16'h0, 0, 16'h9, 0, 16'h0, 9'h0,   0, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("rst_drain");
        rst_n = 1'b1;
        step("D.f0",    0, 0, 16'h0, 0, 16'h0, 1, 16'h0, 9'h020, 0, 1);
        step("D.f1",    0, 0, 16'h0, 0, 16'h1, 1, 16'h1, 9'h021, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
